// File: rtl/mfa_ram_pkg.sv
// Shared types and helpers for the matrix RAM read scheduler.
// Holds the scheduler state encoding and the round-robin index search.
package mfa_ram_pkg;

    localparam int ADDR_LEN_DEF = 16;
    localparam int DATA_LEN_DEF = 8;
    localparam int MAX_REQ      = 32;

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        BURST = 1'b1
    } sched_state_e;

    // First set bit of vld[n-1:0] searching upward from ptr+1 with wrap; ptr when none set.
    function automatic int rr_next_idx(input logic [MAX_REQ-1:0] vld, input int ptr, input int n);
        int idx;
        int res;
        res = ptr;
        for (int i = n; i >= 1; i--) begin
            idx = ptr + i;
            if (idx >= n) begin
                idx = idx - n;
            end else begin
                idx = idx;
            end
            if (vld[idx[4:0]]) begin
                res = idx;
            end else begin
                res = res;
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/ram_rd_sched_rr_arbiter.sv
// Combinational round-robin arbiter: one-hot grant to the first requester above ptr_i.
module rr_arbiter
    import mfa_ram_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = 2
) (
    input  logic [NUM_REQ-1:0] req_i,
    input  logic [ID_W-1:0]    ptr_i,
    output logic [NUM_REQ-1:0] gnt_o,
    output logic [ID_W-1:0]    gnt_id_o,
    output logic               any_o
);

    logic [MAX_REQ-1:0] req_ext_s;
    int                 win_s;

    // Winner search and one-hot grant decode
    always_comb begin
        req_ext_s                = '0;
        req_ext_s[NUM_REQ-1:0]   = req_i;
        win_s                    = rr_next_idx(req_ext_s, int'(ptr_i), NUM_REQ);
        any_o                    = |req_i;
        gnt_id_o                 = win_s[ID_W-1:0];
        gnt_o                    = '0;
        if (any_o) begin
            gnt_o[win_s[ID_W-1:0]] = 1'b1;
        end else begin
            gnt_o = '0;
        end
    end

endmodule

// File: rtl/ram_rd_sched.sv
// Burst read scheduler sharing one registered-read RAM port among NUM_REQ requesters.
// Optional macro RD_WR_FWD_EN forwards same-cycle write data onto a colliding read.
module ram_rd_sched
    import mfa_ram_pkg::*;
#(
    parameter int ADDR_LEN = ADDR_LEN_DEF,
    parameter int DATA_LEN = DATA_LEN_DEF,
    parameter int NUM_REQ  = 4,
    parameter int LEN_W    = 8,
    localparam int ID_W    = (($clog2(NUM_REQ) > 1) ? $clog2(NUM_REQ) : 1)
) (
    input  logic                        CLK,
    input  logic                        RST,
    input  logic [NUM_REQ-1:0]          req_vld,
    input  logic [NUM_REQ*ADDR_LEN-1:0] req_base,
    input  logic [NUM_REQ*LEN_W-1:0]    req_len,
    output logic [NUM_REQ-1:0]          req_rdy,
    input  logic                        wr_en_in,
    input  logic [ADDR_LEN-1:0]         wr_addr_in,
    input  logic [DATA_LEN-1:0]         wr_data_in,
    output logic                        ram_wr_en,
    output logic [ADDR_LEN-1:0]         ram_wr_addr,
    output logic [DATA_LEN-1:0]         ram_wr_data,
    output logic [ADDR_LEN-1:0]         ram_rd_addr,
    input  logic [DATA_LEN-1:0]         ram_q,
    output logic                        rsp_vld,
    output logic [ID_W-1:0]             rsp_id,
    output logic [DATA_LEN-1:0]         rsp_data,
    output logic                        rsp_last,
    output logic                        busy
);

    sched_state_e          state_q, state_d;
    logic [ID_W-1:0]       ptr_q, ptr_d;
    logic [ID_W-1:0]       id_q, id_d;
    logic [LEN_W-1:0]      len_q, len_d;
    logic [LEN_W-1:0]      cnt_q, cnt_d;
    logic [ADDR_LEN-1:0]   rd_addr_q, rd_addr_d;
    logic                  iss_q, iss_d;
    logic                  last_q, last_d;
    logic [ID_W-1:0]       rsp_id_q, rsp_id_d;
    logic [NUM_REQ-1:0]    req_rdy_s;

    logic [NUM_REQ-1:0]    gnt_s;
    logic [ID_W-1:0]       gnt_id_s;
    logic                  any_s;
    logic [ADDR_LEN-1:0]   sel_base_s;
    logic [LEN_W-1:0]      sel_len_s;

    rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .ID_W    (ID_W)
    ) u_arb (
        .req_i    (req_vld),
        .ptr_i    (ptr_q),
        .gnt_o    (gnt_s),
        .gnt_id_o (gnt_id_s),
        .any_o    (any_s)
    );

    // Select the winner's base address and length
    always_comb begin
        sel_base_s = '0;
        sel_len_s  = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (gnt_id_s == ID_W'(i)) begin
                sel_base_s = req_base[i*ADDR_LEN +: ADDR_LEN];
                sel_len_s  = req_len[i*LEN_W +: LEN_W];
            end else begin
                sel_base_s = sel_base_s;
                sel_len_s  = sel_len_s;
            end
        end
    end

    // Next-state logic: grant in IDLE, one read issue per cycle in BURST
    always_comb begin
        state_d   = state_q;
        ptr_d     = ptr_q;
        id_d      = id_q;
        len_d     = len_q;
        cnt_d     = cnt_q;
        rd_addr_d = rd_addr_q;
        iss_d     = 1'b0;
        last_d    = 1'b0;
        rsp_id_d  = rsp_id_q;
        req_rdy_s = '0;
        case (state_q)
            IDLE: begin
                if (any_s) begin
                    req_rdy_s = gnt_s;
                    ptr_d     = gnt_id_s;
                    id_d      = gnt_id_s;
                    len_d     = sel_len_s;
                    cnt_d     = '0;
                    rd_addr_d = sel_base_s;
                    state_d   = BURST;
                end else begin
                    state_d   = IDLE;
                end
            end
            BURST: begin
                iss_d    = 1'b1;
                last_d   = (cnt_q == len_q);
                rsp_id_d = id_q;
                if (cnt_q == len_q) begin
                    state_d = IDLE;
                end else begin
                    cnt_d     = cnt_q + LEN_W'(1);
                    rd_addr_d = rd_addr_q + ADDR_LEN'(1);
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and pipeline registers
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q   <= IDLE;
            ptr_q     <= ID_W'(NUM_REQ - 1);
            id_q      <= '0;
            len_q     <= '0;
            cnt_q     <= '0;
            rd_addr_q <= '0;
            iss_q     <= 1'b0;
            last_q    <= 1'b0;
            rsp_id_q  <= '0;
        end else begin
            state_q   <= state_d;
            ptr_q     <= ptr_d;
            id_q      <= id_d;
            len_q     <= len_d;
            cnt_q     <= cnt_d;
            rd_addr_q <= rd_addr_d;
            iss_q     <= iss_d;
            last_q    <= last_d;
            rsp_id_q  <= rsp_id_d;
        end
    end

`ifdef RD_WR_FWD_EN
    logic                fwd_hit_q;
    logic [DATA_LEN-1:0] fwd_data_q;

    // Capture a write hitting the address being issued this cycle
    always_ff @(posedge CLK) begin
        if (RST) begin
            fwd_hit_q  <= 1'b0;
            fwd_data_q <= '0;
        end else begin
            fwd_hit_q  <= (state_q == BURST) && wr_en_in && (wr_addr_in == rd_addr_q);
            fwd_data_q <= wr_data_in;
        end
    end

    assign rsp_data = fwd_hit_q ? fwd_data_q : ram_q;
`else
    assign rsp_data = ram_q;
`endif

    // No accept pulse while reset is asserted, since the edge would discard it
    assign req_rdy     = RST ? '0 : req_rdy_s;
    assign ram_wr_en   = wr_en_in;
    assign ram_wr_addr = wr_addr_in;
    assign ram_wr_data = wr_data_in;
    assign ram_rd_addr = rd_addr_q;
    assign rsp_vld     = iss_q;
    assign rsp_last    = last_q;
    assign rsp_id      = rsp_id_q;
    assign busy        = (state_q == BURST);

endmodule

// File: tb/tb_ram_rd_sched.sv
// Scoreboard bench for ram_rd_sched with a 1-cycle registered RAM model.
module tb_ram_rd_sched;

    logic        CLK = 1'b0;
    logic        RST;
    logic [3:0]  req_vld;
    logic [63:0] req_base;
    logic [31:0] req_len;
    logic [3:0]  req_rdy;
    logic        wr_en_in;
    logic [15:0] wr_addr_in;
    logic [7:0]  wr_data_in;
    logic        ram_wr_en;
    logic [15:0] ram_wr_addr;
    logic [7:0]  ram_wr_data;
    logic [15:0] ram_rd_addr;
    logic [7:0]  ram_q;
    logic        rsp_vld;
    logic [1:0]  rsp_id;
    logic [7:0]  rsp_data;
    logic        rsp_last;
    logic        busy;

    typedef struct {
        logic [1:0] id;
        logic [7:0] data;
        logic       last;
    } exp_t;

    exp_t        exp_q[$];
    int          n_chk  = 0;
    int          n_pass = 0;
    int          cyc    = 0;
    logic [7:0]  mem [0:65535];
    logic [15:0] tb_base [4];
    logic [7:0]  tb_len  [4];

    ram_rd_sched dut (
        .CLK(CLK), .RST(RST),
        .req_vld(req_vld), .req_base(req_base), .req_len(req_len), .req_rdy(req_rdy),
        .wr_en_in(wr_en_in), .wr_addr_in(wr_addr_in), .wr_data_in(wr_data_in),
        .ram_wr_en(ram_wr_en), .ram_wr_addr(ram_wr_addr), .ram_wr_data(ram_wr_data),
        .ram_rd_addr(ram_rd_addr), .ram_q(ram_q),
        .rsp_vld(rsp_vld), .rsp_id(rsp_id), .rsp_data(rsp_data), .rsp_last(rsp_last),
        .busy(busy)
    );

    always #5 CLK = ~CLK;

    always @(posedge CLK) cyc <= cyc + 1;

    // RAM model: registered read returns old data on a same-address write
    always @(posedge CLK) begin
        ram_q <= mem[ram_rd_addr];
        if (ram_wr_en) mem[ram_wr_addr] <= ram_wr_data;
    end

    function automatic logic [7:0] pat(input logic [15:0] a);
        return a[7:0] ^ a[15:8] ^ 8'h3C;
    endfunction

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", nm, act, exp);
    endtask

    // Monitor: every response must match the head of the expected queue
    always @(negedge CLK) begin
        if (rsp_vld === 1'b1) begin
            if (exp_q.size() == 0) begin
                check("unexpected_rsp", {21'd0, rsp_id, rsp_data, rsp_last}, 32'hFFFFFFFF);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                check("rsp", {21'd0, rsp_id, rsp_data, rsp_last}, {21'd0, e.id, e.data, e.last});
            end
        end
    end

    task automatic set_req(input int i, input logic [15:0] b, input logic [7:0] l);
        tb_base[i] = b;
        tb_len[i]  = l;
        req_base[i*16 +: 16] = b;
        req_len[i*8 +: 8]    = l;
    endtask

    // Called at posedge+1 with requests driven; returns at posedge+1 of the first issue cycle
    task automatic wait_grant(input int exp_id, input bit hold, input bit push, output int gcyc);
        int          n;
        logic [3:0]  onehot;
        logic [15:0] a;
        n = 0;
        onehot = 4'b0001 << exp_id;
        #1;
        while (req_rdy == 4'b0000 && n < 40) begin
            @(posedge CLK); #2;
            n++;
        end
        gcyc = cyc;
        check("grant", {28'd0, req_rdy}, {28'd0, onehot});
        if (push && n < 40) begin
            for (int k = 0; k <= int'(tb_len[exp_id]); k++) begin
                a = tb_base[exp_id] + k[15:0];
                exp_q.push_back('{id: exp_id[1:0], data: mem[a], last: (k == int'(tb_len[exp_id]))});
            end
        end
        @(posedge CLK); #1;
        if (!hold) req_vld[exp_id] = 1'b0;
    endtask

    initial begin
        int          g, prev;
        int          order [5] = '{0, 1, 2, 3, 0};
        logic [15:0] hold_addr;
        logic [7:0]  col_exp;

        for (int a = 0; a < 65536; a++) mem[a] = pat(a[15:0]);
        mem[16'h0020] = 8'h11;
        RST = 1'b1; req_vld = 4'hF; req_base = '0; req_len = '0;
        wr_en_in = 1'b0; wr_addr_in = '0; wr_data_in = '0;

        // Reset state, including no accept pulse while reset is held
        repeat (3) @(posedge CLK);
        #1;
        check("rst_req_rdy", {28'd0, req_rdy}, 32'd0);
        check("rst_rsp_vld", {31'd0, rsp_vld}, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_rd_addr", {16'd0, ram_rd_addr}, 32'd0);
        check("rst_last_id", {29'd0, rsp_last, rsp_id}, 32'd0);
        req_vld = 4'h0;
        @(posedge CLK); #1;
        RST = 1'b0;
        @(posedge CLK); #1;

        // Single burst: requester 0, base 0x10, four words
        set_req(0, 16'h0010, 8'd3);
        req_vld = 4'b0001;
        wait_grant(0, 1'b0, 1'b1, g);
        check("single_busy", {31'd0, busy}, 32'd1);
        for (int k = 0; k < 4; k++) begin
            if (k > 0) begin @(posedge CLK); #1; end
            check("single_addr", {16'd0, ram_rd_addr}, 32'h10 + k);
        end
        @(posedge CLK); #1;
        check("single_busy_end", {31'd0, busy}, 32'd0);
        repeat (2) @(posedge CLK); #1;

        // Address wrap across the top of the space
        set_req(3, 16'hFFFE, 8'd3);
        req_vld = 4'b1000;
        wait_grant(3, 1'b0, 1'b1, g);
        check("wrap_a0", {16'd0, ram_rd_addr}, 32'h0000FFFE);
        @(posedge CLK); #1; check("wrap_a1", {16'd0, ram_rd_addr}, 32'h0000FFFF);
        @(posedge CLK); #1; check("wrap_a2", {16'd0, ram_rd_addr}, 32'h00000000);
        @(posedge CLK); #1; check("wrap_a3", {16'd0, ram_rd_addr}, 32'h00000001);
        repeat (3) @(posedge CLK); #1;

        // Round-robin with all four held: order 0,1,2,3,0 at one grant per 2 cycles
        set_req(0, 16'h0030, 8'd0);
        set_req(1, 16'h0040, 8'd0);
        set_req(2, 16'h0050, 8'd0);
        set_req(3, 16'h0060, 8'd0);
        req_vld = 4'hF;
        prev = 0;
        for (int i = 0; i < 5; i++) begin
            wait_grant(order[i], 1'b1, 1'b1, g);
            if (i > 0) check("rr_interval", g - prev, 32'd2);
            prev = g;
        end
        req_vld = 4'h0;
        repeat (3) @(posedge CLK); #1;

        // Read/write collision on 0x0020
`ifdef RD_WR_FWD_EN
        col_exp = 8'hA5;
`else
        col_exp = 8'h11;
`endif
        set_req(1, 16'h0020, 8'd0);
        req_vld = 4'b0010;
        wait_grant(1, 1'b0, 1'b0, g);
        wr_en_in = 1'b1; wr_addr_in = 16'h0020; wr_data_in = 8'hA5;
        exp_q.push_back('{id: 2'd1, data: col_exp, last: 1'b1});
        #1;
        check("col_rd_addr", {16'd0, ram_rd_addr}, 32'h20);
        check("wr_passthru", {7'd0, ram_wr_en, ram_wr_addr, ram_wr_data}, {7'd0, 1'b1, 16'h0020, 8'hA5});
        @(posedge CLK); #1;
        wr_en_in = 1'b0;
        repeat (3) @(posedge CLK); #1;

        // Reset on the third issue of an 8-word burst: only two words come back
        set_req(2, 16'h0100, 8'd7);
        req_vld = 4'b0100;
        wait_grant(2, 1'b0, 1'b0, g);
        exp_q.push_back('{id: 2'd2, data: pat(16'h0100), last: 1'b0});
        exp_q.push_back('{id: 2'd2, data: pat(16'h0101), last: 1'b0});
        @(posedge CLK); #1;
        @(posedge CLK); #1;
        check("rst_mid_addr", {16'd0, ram_rd_addr}, 32'h102);
        RST = 1'b1;
        @(posedge CLK); #1;
        check("rst_mid_rsp_vld", {31'd0, rsp_vld}, 32'd0);
        check("rst_mid_busy", {31'd0, busy}, 32'd0);
        RST = 1'b0;
        set_req(0, 16'h0070, 8'd0);
        set_req(1, 16'h0080, 8'd0);
        set_req(2, 16'h0090, 8'd0);
        set_req(3, 16'h00A0, 8'd0);
        req_vld = 4'hF;
        wait_grant(0, 1'b1, 1'b1, g);
        req_vld = 4'h0;
        repeat (3) @(posedge CLK); #1;

        // Idle hold: nothing moves for 10 cycles
        hold_addr = ram_rd_addr;
        for (int i = 0; i < 10; i++) begin
            @(posedge CLK); #1;
            check("idle_hold", {14'd0, rsp_vld, busy, ram_rd_addr}, {14'd0, 1'b0, 1'b0, hold_addr});
        end

        repeat (4) @(posedge CLK); #1;
        check("queue_drained", exp_q.size(), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/ram_rd_sched.md
Name: ram_rd_sched

Overview:
- Burst read scheduler that shares the single read port of the matrix RAM (1-cycle registered read) between NUM_REQ requesters.
- Each requester posts a burst (base address, length); the scheduler grants round-robin and issues one read per cycle for the burst.
- Returns data tagged with requester id and a last flag.
- The RAM write port passes through unchanged, so the scheduler can track read/write collisions.

Parameters:
- ADDR_LEN, 16, RAM address width
- DATA_LEN, 8, RAM word width
- NUM_REQ, 4, number of read requesters (>=2)
- LEN_W, 8, burst length field width; burst = req_len+1 words
- Derived localparam ID_W = max(1, $clog2(NUM_REQ))

Ports:
- CLK  in  1  clock
- RST  in  1  synchronous active-high reset
- req_vld  in  NUM_REQ  burst request per requester
- req_base  in  NUM_REQ*ADDR_LEN  flattened burst base addresses; slice i = requester i
- req_len  in  NUM_REQ*LEN_W  flattened burst lengths minus one
- req_rdy  out  NUM_REQ  one-hot accept pulse
- wr_en_in / wr_addr_in / wr_data_in  in  1/ADDR_LEN/DATA_LEN  write request from the loader
- ram_wr_en / ram_wr_addr / ram_wr_data  out  1/ADDR_LEN/DATA_LEN  to RAM write port; combinational pass-through
- ram_rd_addr  out  ADDR_LEN  to RAM read address
- ram_q  in  DATA_LEN  RAM read data, valid one cycle after address
- rsp_vld  out  1  response data valid
- rsp_id  out  ID_W  requester owning rsp_data
- rsp_data  out  DATA_LEN  read word
- rsp_last  out  1  final word of burst
- busy  out  1  high while in BURST

Behaviour:
- FSM states: IDLE, BURST.
- Reset values: state=IDLE; ram_rd_addr=0; rsp_vld=0; rsp_last=0; rsp_id=0; req_rdy=0; busy=0; round-robin pointer=NUM_REQ-1, so requester 0 wins first.
- IDLE, any req_vld set:
  - Winner = first set bit searching from pointer+1 upward with wrap.
  - req_rdy[winner]=1 combinationally, that cycle only.
  - Capture base/len/id at the edge; pointer<=winner; go to BURST.
- IDLE, no request: req_rdy=0; stay in IDLE.
- BURST:
  - Cycle k (k=0..len) drives registered ram_rd_addr = base+k, mod 2^ADDR_LEN (wraps 0xFFFF->0x0000).
  - Issue flag and last flag (k==len) are registered one stage.
  - Next cycle: rsp_vld=1, rsp_id=captured id, rsp_data=ram_q, rsp_last=1 on final word.
- After the k==len issue, return to IDLE. Exactly one idle cycle separates bursts; len+1 words take len+2 cycles per grant.
- Latency: request accepted in cycle t -> first rsp_vld in cycle t+2.
- Requests are not accepted during BURST; req_vld must be held until req_rdy.
- No response backpressure; the consumer must accept every rsp_vld.
- Read-during-write, same address, same cycle: rsp_data is the old RAM contents (without the optional feature).
- Reset mid-burst: burst aborted; any in-flight response dropped (rsp_vld=0 the cycle after RST); pointer reinitialised.
- req_len=0: single-word burst with rsp_last=1 on that word.

Optional Feature:
- Macro RD_WR_FWD_EN.
- Defined: if ram_rd_addr==wr_addr_in with wr_en_in=1 in the issue cycle, register the match and wr_data_in. The response then returns the forwarded write data instead of ram_q.
- Undefined: no compare logic; old data returned.

Decomposition:
- Package mfa_ram_pkg:
  - ADDR_LEN/DATA_LEN defaults
  - state enum type (IDLE, BURST)
  - function for the round-robin next-index search
- Sub-module rr_arbiter (NUM_REQ-wide round-robin grant with pointer input), instantiated once.

Test Plan:
- Single request: req_vld=0001, base=0x0010, len=3 -> req_rdy[0] pulse; ram_rd_addr 0x10..0x13 on 4 consecutive cycles; rsp_vld from t+2 with data mem[0x10..0x13]; rsp_id=0; rsp_last on the 4th word.
- Round-robin: all four requesting, len=0, held -> grant order 0,1,2,3,0; one response per 2 cycles.
- Wrap: base=0xFFFE, len=3 -> addresses FFFE, FFFF, 0000, 0001.
- Collision: write 0xA5 to 0x0020 in the same cycle a burst reads 0x0020 (old value 0x11) -> rsp_data=0x11 without the macro, 0xA5 with RD_WR_FWD_EN.
- Reset mid-burst: RST at 3rd issue of len=7 -> next cycle rsp_vld=0, busy=0; after release, requester 0 is granted first.
- Idle hold: no req_vld for 10 cycles -> rsp_vld=0, busy=0, ram_rd_addr stable.
